// File: rtl/bp_be_retire_seq_nw_if.sv
// Dispatch / retire bundle for the N-wide retire sequencer.
// master drives dispatch and retire strobes, slave forms retire packets.
interface bp_be_retire_seq_nw_if #(
  parameter int issue_width_p = 2,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int dword_width_p = 64,
  parameter int exc_width_p   = 16
);
  localparam int N  = issue_width_p;
  localparam int VW = vaddr_width_p;
  localparam int IW = instr_width_p;
  localparam int DW = dword_width_p;
  localparam int EW = exc_width_p;

  logic                 flush_i;
  logic [N-1:0]         disp_v_i;
  logic [N-1:0][VW-1:0] disp_pc_i;
  logic [N-1:0][IW-1:0] disp_instr_i;
  logic [N-1:0][DW-1:0] disp_rs1_i;
  logic [N-1:0][DW-1:0] disp_imm_i;
  logic [N-1:0]         retire_v_i;
  logic [N-1:0][EW-1:0] retire_exc_i;
  logic [N-1:0][DW-1:0] retire_data_i;

  logic [N-1:0]         ret_v_o;
  logic [N-1:0]         ret_instret_o;
  logic [N-1:0][VW-1:0] ret_pc_o;
  logic [N-1:0][VW-1:0] ret_npc_o;
  logic [N-1:0]         ret_npc_fb_o;
  logic [N-1:0][VW-1:0] ret_vaddr_o;
  logic [N-1:0][IW-1:0] ret_instr_o;
  logic [N-1:0][DW-1:0] ret_data_o;
  logic [N-1:0][EW-1:0] ret_exc_o;
  logic [63:0]          instret_cnt_o;
  logic                 err_o;

  modport master (
    output flush_i,
    output disp_v_i,
    output disp_pc_i,
    output disp_instr_i,
    output disp_rs1_i,
    output disp_imm_i,
    output retire_v_i,
    output retire_exc_i,
    output retire_data_i,
    input  ret_v_o,
    input  ret_instret_o,
    input  ret_pc_o,
    input  ret_npc_o,
    input  ret_npc_fb_o,
    input  ret_vaddr_o,
    input  ret_instr_o,
    input  ret_data_o,
    input  ret_exc_o,
    input  instret_cnt_o,
    input  err_o
  );

  modport slave (
    input  flush_i,
    input  disp_v_i,
    input  disp_pc_i,
    input  disp_instr_i,
    input  disp_rs1_i,
    input  disp_imm_i,
    input  retire_v_i,
    input  retire_exc_i,
    input  retire_data_i,
    output ret_v_o,
    output ret_instret_o,
    output ret_pc_o,
    output ret_npc_o,
    output ret_npc_fb_o,
    output ret_vaddr_o,
    output ret_instr_o,
    output ret_data_o,
    output ret_exc_o,
    output instret_cnt_o,
    output err_o
  );
endinterface

// File: rtl/bp_be_retire_seq_nw.sv
// N-wide retire bookkeeping: shadow pipe of dispatch info aligned to retire
// strobes, program-order npc, younger-slot squash and instret counting.
module bp_be_retire_seq_nw #(
  parameter int issue_width_p = 2,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int dword_width_p = 64,
  parameter int exc_width_p   = 16,
  parameter int latency_p     = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bp_be_retire_seq_nw_if.slave bus
);
  localparam int N  = issue_width_p;
  localparam int VW = vaddr_width_p;
  localparam int IW = instr_width_p;
  localparam int DW = dword_width_p;
  localparam int LS = latency_p - 1;
  localparam int LA = (latency_p > 1) ? latency_p - 2 : 0;

  typedef logic [N-1:0][VW-1:0] pc_vec_t;
  typedef logic [N-1:0][IW-1:0] ins_vec_t;

  logic [N-1:0] v_q     [latency_p];
  pc_vec_t      pc_q    [latency_p];
  ins_vec_t     instr_q [latency_p];
  pc_vec_t      va_q    [latency_p];
  logic [63:0]  cnt_q;
  logic         err_q;

  logic [N-1:0][DW-1:0] disp_sum;
  pc_vec_t              disp_va;
  logic                 unused_sum_hi;

  always_comb begin
    disp_sum      = '0;
    disp_va       = '0;
    unused_sum_hi = 1'b0;
    for (int i = 0; i < N; i++) begin
      disp_sum[i]   = bus.disp_rs1_i[i]
                    + bus.disp_imm_i[i];
      disp_va[i]    = disp_sum[i][VW-1:0];
      unused_sum_hi = unused_sum_hi
                    ^ (^disp_sum[i][DW-1:VW]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < latency_p; s++) begin
        v_q[s]     <= '0;
        pc_q[s]    <= '0;
        instr_q[s] <= '0;
        va_q[s]    <= '0;
      end
    end else begin
      v_q[0]     <= bus.flush_i ? '0 : bus.disp_v_i;
      pc_q[0]    <= bus.disp_pc_i;
      instr_q[0] <= bus.disp_instr_i;
      va_q[0]    <= disp_va;
      for (int s = 1; s < latency_p; s++) begin
        v_q[s]     <= bus.flush_i ? '0 : v_q[s-1];
        pc_q[s]    <= pc_q[s-1];
        instr_q[s] <= instr_q[s-1];
        va_q[s]    <= va_q[s-1];
      end
    end
  end

  logic [N-1:0] sl_v;
  pc_vec_t      sl_pc;
  logic [N-1:0] la_v;
  pc_vec_t      la_pc;
  logic [N-1:0] raw;
  logic [N-1:0] exc_any;
  logic [N-1:0] squash;
  logic [N-1:0] ret_v;
  logic [N-1:0] ret_ok;
  logic [N-1:0] orphan;
  pc_vec_t      npc;
  logic [N-1:0] fb;
  logic         hit;
  logic         found;
  logic [63:0]  inc;

  // lookahead group supplies npc for the youngest valid slot
  always_comb begin
    sl_v  = v_q[LS];
    sl_pc = pc_q[LS];
    if (latency_p == 1) begin
      la_v  = bus.disp_v_i & ~{N{bus.flush_i}};
      la_pc = bus.disp_pc_i;
    end else begin
      la_v  = v_q[LA];
      la_pc = pc_q[LA];
    end
  end

  always_comb begin
    raw     = bus.retire_v_i & sl_v;
    orphan  = bus.retire_v_i & ~sl_v;
    exc_any = '0;
    squash  = '0;
    hit     = 1'b0;
    for (int i = 0; i < N; i++) begin
      exc_any[i] = |bus.retire_exc_i[i];
      squash[i]  = hit;
      if (raw[i] && exc_any[i]) begin
        hit = 1'b1;
      end
    end
    ret_v  = raw & ~squash;
    ret_ok = ret_v & ~exc_any;
  end

  always_comb begin
    npc   = '0;
    fb    = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (j > i && sl_v[j] && !found) begin
          npc[i] = sl_pc[j];
          found  = 1'b1;
        end
      end
      for (int j = 0; j < N; j++) begin
        if (la_v[j] && !found) begin
          npc[i] = la_pc[j];
          found  = 1'b1;
        end
      end
      if (!found) begin
        npc[i] = sl_pc[i] + VW'(4);
      end
      fb[i] = !found;
    end
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < N; i++) begin
      inc = inc + 64'(ret_ok[i]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + inc;
      if (|orphan) begin
        err_q <= 1'b1;
      end
    end
  end

  // packet fields are zeroed on slots that do not retire
  always_comb begin
    bus.ret_v_o       = ret_v;
    bus.ret_instret_o = ret_ok;
    bus.ret_pc_o      = '0;
    bus.ret_npc_o     = '0;
    bus.ret_npc_fb_o  = '0;
    bus.ret_vaddr_o   = '0;
    bus.ret_instr_o   = '0;
    bus.ret_data_o    = '0;
    bus.ret_exc_o     = '0;
    for (int i = 0; i < N; i++) begin
      if (ret_v[i]) begin
        bus.ret_pc_o[i]     = sl_pc[i];
        bus.ret_npc_o[i]    = npc[i];
        bus.ret_npc_fb_o[i] = fb[i];
        bus.ret_vaddr_o[i]  = va_q[LS][i];
        bus.ret_instr_o[i]  = instr_q[LS][i];
        bus.ret_data_o[i]   = bus.retire_data_i[i];
        bus.ret_exc_o[i]    = bus.retire_exc_i[i];
      end
    end
    bus.instret_cnt_o = cnt_q;
    bus.err_o         = err_q;
  end
endmodule
